// File: rtl/fetch_if.sv
// Handshake bundle between the fetch unit, instruction memory, decode and branch resolution.
// The master modport is the fetch unit's view of the bundle.
interface fetch_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [10:0] opcode;
    logic [63:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_taken;
    logic [63:0] br_target;

    modport master (
        output imem_req, imem_addr, instr_out, opcode, pc_out, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, br_taken, br_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_out, opcode, pc_out, instr_valid,
        output imem_ack, imem_rdata, instr_ready, br_taken, br_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: issues one memory request, holds the returned word
// until decode accepts it, and redirects on a taken branch.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    typedef enum logic [1:0] {StStart, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [63:0] br_pc;

    // Redirect targets are word-aligned.
    assign br_pc = {bus.br_target[63:2], 2'b00};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        req_d    = req_q;
        valid_d  = valid_q;
        if (bus.br_taken) begin
            // A branch wins over any ack or accept in the same cycle.
            pc_d    = br_pc;
            addr_d  = br_pc;
            req_d   = 1'b1;
            valid_d = 1'b0;
            state_d = StWait;
        end else begin
            unique case (state_q)
                StStart: begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = StWait;
                end
                StWait: begin
                    if (bus.imem_ack) begin
                        instr_d  = bus.imem_rdata;
                        pc_out_d = addr_q;
                        valid_d  = 1'b1;
                        req_d    = 1'b0;
                        pc_d     = pc_q + 64'd4;
                        state_d  = StHold;
                    end
                end
                StHold: begin
                    if (bus.instr_ready) begin
                        valid_d = 1'b0;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = StWait;
                    end
                end
                default: state_d = StStart;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StStart;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            pc_out_q <= 64'h0;
            instr_q  <= 32'h0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_out   = instr_q;
    assign bus.opcode      = instr_q[31:21];
    assign bus.pc_out      = pc_out_q;
    assign bus.instr_valid = valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random checks of fetch_unit against a transaction-level model of
// the request/held-instruction slots.
module tb_fetch_unit;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    fetch_if bus_if ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one request slot and one held-instruction slot.
    logic        m_req;
    logic        m_valid;
    logic [63:0] m_addr;
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    logic [63:0] m_pcout;

    task automatic model_reset();
        m_req   = 1'b0;
        m_valid = 1'b0;
        m_addr  = 64'h0;
        m_pc    = 64'h0;
        m_instr = 32'h0;
        m_pcout = 64'h0;
    endtask

    task automatic model_update();
        if (bus_if.br_taken) begin
            m_pc    = bus_if.br_target & ~64'd3;
            m_addr  = m_pc;
            m_req   = 1'b1;
            m_valid = 1'b0;
        end else if (m_req && bus_if.imem_ack) begin
            m_instr = bus_if.imem_rdata;
            m_pcout = m_addr;
            m_valid = 1'b1;
            m_req   = 1'b0;
            m_pc    = m_pc + 64'd4;
        end else if (m_valid && bus_if.instr_ready) begin
            m_valid = 1'b0;
            m_req   = 1'b1;
            m_addr  = m_pc;
        end else if (!m_req && !m_valid) begin
            m_req  = 1'b1;
            m_addr = m_pc;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_req", {63'd0, bus_if.imem_req}, {63'd0, m_req});
        chk("imem_addr", bus_if.imem_addr, m_addr);
        chk("instr_valid", {63'd0, bus_if.instr_valid}, {63'd0, m_valid});
        chk("instr_out", {32'd0, bus_if.instr_out}, {32'd0, m_instr});
        chk("opcode", {53'd0, bus_if.opcode}, {53'd0, m_instr[31:21]});
        chk("pc_out", bus_if.pc_out, m_pcout);
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic ready,
                         input logic br, input logic [63:0] tgt);
        bus_if.imem_ack    = ack;
        bus_if.imem_rdata  = rdata;
        bus_if.instr_ready = ready;
        bus_if.br_taken    = br;
        bus_if.br_target   = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    // Reset pulse between edges with an ack offered while reset is held.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 64'h0);
        @(posedge clk);
        #1 check_all();
        #2 rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        model_reset();
        #1 rst = 1'b1;
        #2 check_all();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;

        // First request after reset, then ack in the first WAIT cycle.
        step();
        chk("first_req", {63'd0, bus_if.imem_req}, 64'd1);
        drive(1'b1, 32'hF840_0000, 1'b0, 1'b0, 64'h0);
        step();
        chk("first_valid", {63'd0, bus_if.instr_valid}, 64'd1);
        chk("first_opcode", {53'd0, bus_if.opcode}, {53'd0, 11'b11111000010});
        chk("first_pc_out", bus_if.pc_out, 64'h0);

        // Stall in HOLD for 5 cycles with stray acks, then accept.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 64'h0);
            step();
        end
        chk("hold_instr", {32'd0, bus_if.instr_out}, 64'hF840_0000);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        step();
        chk("accept_req", {63'd0, bus_if.imem_req}, 64'd1);
        chk("accept_addr", bus_if.imem_addr, 64'h4);

        // Branch colliding with an ack: word discarded.
        drive(1'b1, 32'hAAAA_AAAA, 1'b0, 1'b1, 64'h103);
        step();
        chk("br_ack_addr", bus_if.imem_addr, 64'h100);
        chk("br_ack_valid", {63'd0, bus_if.instr_valid}, 64'd0);
        chk("br_ack_pc_out", bus_if.pc_out, 64'h0);
        drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 64'h0);
        step();
        chk("br_fetch_pc_out", bus_if.pc_out, 64'h100);

        // Branch with accept in HOLD: flush.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 64'h200);
        step();
        chk("br_rdy_valid", {63'd0, bus_if.instr_valid}, 64'd0);
        chk("br_rdy_addr", bus_if.imem_addr, 64'h200);

        // PC wrap at the top of the address space.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        drive(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 64'h0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        step();
        chk("wrap_addr", bus_if.imem_addr, 64'h0);

        // Asynchronous reset while in WAIT.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h40);
        step();
        pulse_reset();
        chk("rst_instr", {32'd0, bus_if.instr_out}, 64'h0);
        step();
        chk("rst_req_addr", bus_if.imem_addr, 64'h0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(1, 0) == 1), $urandom, ($urandom_range(1, 0) == 1),
                  ($urandom_range(9, 0) == 0),
                  {$urandom, $urandom_range(3, 0) == 0 ? 32'hFFFF_FFFC : $urandom});
            step();
            if ($urandom_range(79, 0) == 0) pulse_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
